jt12_slot_seq: RTL and testbench
================================

# jt12_slot_seq

Slot sequencer for the FM operator/accumulator datapath. Runs the 24-slot operator schedule (6 channels × 4 operators), produces the one-hot `s1..s4_enters` group flags, and presents each channel's algorithm, output routing and PCM enable. Flags and per-channel fields are delayed to line up with the operator pipeline. It sits between the register file and the channel accumulator and is the single timing master for one output sample.

## Interface
Parameters:
- OP_LAT, 4: cycles from slot issue to operator result at the accumulator input (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- clk_en  in  1  slot advance enable; all state holds when low
- cfg_we  in  1  per-channel config write strobe
- cfg_ch  in  3  channel 0..5; 6 and 7 are ignored
- cfg_alg  in  3  algorithm for cfg_ch
- cfg_rl  in  2  {left, right} enables for cfg_ch
- dac_en  in  1  channel-5 PCM replaces FM
- slot  out  5  issue-side slot counter, 0..23
- cur_ch  out  3  issue-side channel
- cur_op  out  2  issue-side group: 0=S1, 1=S3, 2=S2, 3=S4
- frame_start  out  1  high during issue slot 0
- s1_enters, s2_enters, s3_enters, s4_enters  out  1 each  delayed group flags, exactly one high after warm-up
- alg  out  3  delayed algorithm of the channel at the accumulator
- rl  out  2  delayed routing
- pcm_en  out  1  delayed; high only for channel 5 when the latched dac_en is 1

## Operation
- Slot counter: 0..23, wraps 23→0. It increments only on cycles where clk_en=1.
  - Group = slot/6, in the order S1, S3, S2, S4.
  - cur_ch = slot mod 6.
- Config storage: 6 live entries {alg, rl}, written on cfg_we & clk_en-independent (every clk).
  - Reset values: alg=0, rl=2'b11.
- Shadow copies: 6 entries.
  - A channel's shadow loads from its live entry at that channel's S1 issue slot (slots 0..5).
  - Alg and rl therefore never change within one channel sum.
  - If a write hits the same channel in the same cycle as its shadow load, the shadow takes the new write data (bypass).
- dac_en is latched at frame_start & clk_en. Issue-side pcm_en = latched dac_en & (cur_ch==5).
- Delay line: {group one-hot, shadow alg, shadow rl, pcm_en} pass through OP_LAT stages.
  - Stages advance only on clk_en.
  - The delay line drives s*_enters, alg, rl, pcm_en.
- Warm-up mask:
  - A counter loads OP_LAT on rst and decrements on clk_en.
  - While it is nonzero, all delayed outputs are forced 0.
  - This removes the need for resettable delay stages.

## Timing
- Reset values: slot=0, cur_ch=0, cur_op=0, frame_start=1 (issue slot 0), all s*_enters=0, alg=0, rl=0, pcm_en=0. The last three are masked during warm-up.
- Warm-up:
  - The first delayed outputs appear on the cycle after OP_LAT clk_en-qualified cycles.
  - At that point s1_enters=1 for channel 0.
- Latency: an issue in slot k appears at the outputs exactly OP_LAT enabled cycles later.
- Each group flag stays high for 6 consecutive enabled cycles. Frame period is 24 enabled cycles.
- clk_en low: every register holds, including the warm-up counter.
  - Outputs keep their last value.
  - Config writes are still accepted.
- rst mid-frame: takes effect on the next clk.
  - Slot returns to 0 and warm-up restarts.
  - Live config returns to reset values.
  - Shadows reload during the next S1 group.
- cfg_ch > 5: write dropped, no side effects.

## Structure
- Shared package (jt12_pkg): slot count 24, channels-per-group 6, group encodings (S1=0, S3=1, S2=2, S4=3), config reset values.
- Sub-module: the existing jt12_sh, instantiated with width 3+2+1+4=10 and stages=OP_LAT, as the alignment delay line.
- Everything else is local: counters, config/shadow arrays, mask.

## Test plan
- Reset, clk_en=1, OP_LAT=4:
  - The first nonzero output is on cycle 5 after rst falls: s1_enters=1.
  - s3_enters rises 6 cycles later.
  - Sequence S1,S3,S2,S4 repeats with period 24.
  - Exactly one flag is high per cycle.
- Write ch2 alg=7, rl=01 at slot 10:
  - The current frame's ch2 output shows the old values.
  - From the next frame, alg=7, rl=01 appear on all 4 ch2 slots.
- Same-cycle write of ch3 alg=5 at issue slot 3: shadow takes 5, visible on the ch3 S1 output OP_LAT later.
- dac_en=1 set mid-frame:
  - pcm_en stays 0 until the next frame.
  - After that, pcm_en=1 on the ch5 slots only (4 pulses per frame).
- clk_en toggled 1-in-3:
  - Slot sequence and alignment are identical to the continuous run, measured in enabled cycles.
  - Outputs are stable across disabled cycles.
- rst pulsed at slot 17:
  - The next cycle shows slot=0 and all s*_enters=0.
  - The warm-up repeats.
  - cfg_ch=6 write: no config change.

Source files
------------

// File: rtl/jt12_pkg.sv
// jt12_pkg
// Shared definitions for the FM slot sequencer: slot schedule geometry,
// operator group encodings and per-channel configuration reset values.
package jt12_pkg;

  localparam int SLOT_CNT   = 24;
  localparam int CH_PER_GRP = 6;

  // Issue order of the four operator groups within one frame.
  typedef enum logic [1:0] {
    GRP_S1 = 2'd0,
    GRP_S3 = 2'd1,
    GRP_S2 = 2'd2,
    GRP_S4 = 2'd3
  } grp_t;

  localparam logic [2:0] ALG_RST = 3'd0;
  localparam logic [1:0] RL_RST  = 2'b11;

  // One-hot group flags packed as {s1, s2, s3, s4}.
  function automatic logic [3:0] grp_onehot(grp_t g);
    case (g)
      GRP_S1:  return 4'b1000;
      GRP_S2:  return 4'b0100;
      GRP_S3:  return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

endpackage

// File: rtl/jt12_sh.sv
// jt12_sh
// Fixed-length shift register used to align control fields with the
// operator pipeline. Stages advance only when clk_en is high. No reset:
// the consumer masks the output until the pipe has filled.
// Ports:
//   clk     clock
//   clk_en  shift enable
//   din     data entering stage 0
//   drop    data leaving the last stage
module jt12_sh #(
  parameter int width  = 5,
  parameter int stages = 24
) (
  input  logic             clk,
  input  logic             clk_en,
  input  logic [width-1:0] din,
  output logic [width-1:0] drop
);

  logic [width-1:0] stg [stages];

  always_ff @(posedge clk) begin
    if (clk_en) begin
      stg[0] <= din;
      for (int i = 1; i < stages; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign drop = stg[stages-1];

endmodule

// File: rtl/jt12_slot_seq.sv
// jt12_slot_seq
// Slot sequencer for the FM operator/accumulator datapath. Walks the
// 24-slot schedule (6 channels x 4 operator groups), keeps live and
// per-sum shadow copies of each channel's algorithm/routing, and delays
// group flags and channel fields by OP_LAT enabled cycles so they meet
// the operator result at the accumulator.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clk_en              slot advance enable (config writes ignore it)
//   cfg_we/ch/alg/rl    per-channel config write; ch 6,7 dropped
//   dac_en              channel-5 PCM enable, sampled at frame start
//   slot/cur_ch/cur_op  issue-side position; frame_start at slot 0
//   s1..s4_enters       delayed one-hot group flags
//   alg, rl, pcm_en     delayed channel fields at the accumulator
module jt12_slot_seq
  import jt12_pkg::*;
#(
  parameter int OP_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       cfg_we,
  input  logic [2:0] cfg_ch,
  input  logic [2:0] cfg_alg,
  input  logic [1:0] cfg_rl,
  input  logic       dac_en,
  output logic [4:0] slot,
  output logic [2:0] cur_ch,
  output logic [1:0] cur_op,
  output logic       frame_start,
  output logic       s1_enters,
  output logic       s2_enters,
  output logic       s3_enters,
  output logic       s4_enters,
  output logic [2:0] alg,
  output logic [1:0] rl,
  output logic       pcm_en
);

  localparam int              WW        = $clog2(OP_LAT + 1);
  localparam logic [WW-1:0]   WARM_LOAD = WW'(OP_LAT);

  grp_t          grp;
  logic [2:0]    ch;
  logic [WW-1:0] warm_cnt;
  logic          dac_lat;

  logic [2:0] live_alg [CH_PER_GRP];
  logic [1:0] live_rl  [CH_PER_GRP];
  logic [2:0] shd_alg  [CH_PER_GRP];
  logic [1:0] shd_rl   [CH_PER_GRP];

  logic       is_s1;
  logic       cfg_valid;
  logic       wr_hit;
  logic [2:0] load_alg;
  logic [1:0] load_rl;
  logic [2:0] iss_alg;
  logic [1:0] iss_rl;
  logic       iss_pcm;
  logic [9:0] pipe_in;
  logic [9:0] pipe_out;
  logic       warm;

  // Schedule counters. ch and grp track slot mod 6 and slot / 6 directly
  // so no divider is needed; grp wraps naturally together with slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot     <= '0;
      ch       <= '0;
      grp      <= GRP_S1;
      warm_cnt <= WARM_LOAD;
      dac_lat  <= 1'b0;
    end else if (clk_en) begin
      if (slot == 5'(SLOT_CNT - 1)) slot <= '0;
      else                          slot <= slot + 5'd1;
      if (ch == 3'(CH_PER_GRP - 1)) begin
        ch  <= '0;
        grp <= grp_t'(grp + 2'd1);
      end else begin
        ch <= ch + 3'd1;
      end
      if (warm_cnt != '0) warm_cnt <= warm_cnt - WW'(1);
      if (frame_start) dac_lat <= dac_en;
    end
  end

  assign frame_start = (slot == 5'd0);
  assign cur_ch      = ch;
  assign cur_op      = grp;

  assign cfg_valid = cfg_we && (cfg_ch < 3'(CH_PER_GRP));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH_PER_GRP; i++) begin
        live_alg[i] <= ALG_RST;
        live_rl[i]  <= RL_RST;
      end
    end else if (cfg_valid) begin
      live_alg[cfg_ch] <= cfg_alg;
      live_rl[cfg_ch]  <= cfg_rl;
    end
  end

  // The shadow of a channel is refreshed at its S1 slot, so one channel sum
  // always sees a single alg/rl. A write landing on that same slot wins.
  assign is_s1    = (grp == GRP_S1);
  assign wr_hit   = cfg_we && (cfg_ch == ch);
  assign load_alg = wr_hit ? cfg_alg : live_alg[ch];
  assign load_rl  = wr_hit ? cfg_rl  : live_rl[ch];

  always_ff @(posedge clk) begin
    if (clk_en && is_s1) begin
      shd_alg[ch] <= load_alg;
      shd_rl[ch]  <= load_rl;
    end
  end

  // During S1 the shadow register is being loaded on this edge, so the
  // pipe takes the value it is loading rather than the stale copy.
  assign iss_alg = is_s1 ? load_alg : shd_alg[ch];
  assign iss_rl  = is_s1 ? load_rl  : shd_rl[ch];
  assign iss_pcm = dac_lat && (ch == 3'd5);

  assign pipe_in = {grp_onehot(grp), iss_alg, iss_rl, iss_pcm};

  jt12_sh #(
    .width  (10),
    .stages (OP_LAT)
  ) u_align (
    .clk    (clk),
    .clk_en (clk_en),
    .din    (pipe_in),
    .drop   (pipe_out)
  );

  // The delay stages are not reset; hide their contents until filled.
  assign warm = (warm_cnt != '0);

  assign s1_enters = ~warm & pipe_out[9];
  assign s2_enters = ~warm & pipe_out[8];
  assign s3_enters = ~warm & pipe_out[7];
  assign s4_enters = ~warm & pipe_out[6];
  assign alg       = warm ? 3'd0 : pipe_out[5:3];
  assign rl        = warm ? 2'd0 : pipe_out[2:1];
  assign pcm_en    = ~warm & pipe_out[0];

endmodule

// File: tb/tb_jt12_slot_seq.sv
module tb_jt12_slot_seq;

  localparam int OP_LAT = 4;

  logic       clk = 1'b0;
  logic       rst, clk_en, cfg_we, dac_en;
  logic [2:0] cfg_ch, cfg_alg;
  logic [1:0] cfg_rl;
  logic [4:0] slot;
  logic [2:0] cur_ch;
  logic [1:0] cur_op;
  logic       frame_start, s1_enters, s2_enters, s3_enters, s4_enters;
  logic [2:0] alg;
  logic [1:0] rl;
  logic       pcm_en;

  always #5 clk = ~clk;

  jt12_slot_seq #(.OP_LAT(OP_LAT)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_alg(cfg_alg), .cfg_rl(cfg_rl), .dac_en(dac_en), .slot(slot),
    .cur_ch(cur_ch), .cur_op(cur_op), .frame_start(frame_start),
    .s1_enters(s1_enters), .s2_enters(s2_enters), .s3_enters(s3_enters),
    .s4_enters(s4_enters), .alg(alg), .rl(rl), .pcm_en(pcm_en)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: n counts enabled edges since reset, the frame position
  // is n mod 24. Each enabled edge records what the accumulator should see
  // OP_LAT enabled edges later.
  typedef struct packed {
    logic [3:0] flags;  // {s1,s2,s3,s4}
    logic [2:0] alg;
    logic [1:0] rl;
    logic       pcm;
  } orec_t;

  int         n = 0;
  bit  [2:0]  m_alg [6];
  bit  [1:0]  m_rl  [6];
  bit  [2:0]  snap_alg [6];
  bit  [1:0]  snap_rl  [6];
  bit         m_dac = 0;
  orec_t      hist [$];

  function automatic logic [3:0] flags_of(int g);
    // issue order within a frame: S1, S3, S2, S4
    case (g)
      0: return 4'b1000;
      1: return 4'b0010;
      2: return 4'b0100;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic void model_edge();
    int s, c, g;
    orec_t r;
    if (rst) begin
      n = 0;
      hist.delete();
      m_dac = 0;
      for (int i = 0; i < 6; i++) begin m_alg[i] = 0; m_rl[i] = 2'b11; end
      return;
    end
    if (clk_en) begin
      s = n % 24; c = s % 6; g = s / 6;
      if (g == 0) begin
        if (cfg_we && cfg_ch == c) begin snap_alg[c] = cfg_alg; snap_rl[c] = cfg_rl; end
        else begin snap_alg[c] = m_alg[c]; snap_rl[c] = m_rl[c]; end
      end
      r.flags = flags_of(g);
      r.alg   = snap_alg[c];
      r.rl    = snap_rl[c];
      r.pcm   = m_dac && (c == 5);
      hist.push_back(r);
      if (s == 0) m_dac = dac_en;
      n++;
    end
    if (cfg_we && cfg_ch < 6) begin m_alg[cfg_ch] = cfg_alg; m_rl[cfg_ch] = cfg_rl; end
  endfunction

  task automatic check_model(input string tag);
    logic [10:0] exp_i, got_i;
    orec_t       exp_d, got_d;
    int s;
    s = n % 24;
    exp_i = {5'(s), 3'(s % 6), 2'(s / 6), (s == 0)};
    got_i = {slot, cur_ch, cur_op, frame_start};
    if (n >= OP_LAT) exp_d = hist[n - OP_LAT];
    else             exp_d = '0;
    got_d = {s1_enters, s2_enters, s3_enters, s4_enters, alg, rl, pcm_en};
    tests++;
    if (got_i !== exp_i) begin
      fails++;
      $display("FAIL %s issue: got slot/ch/op/fs=%h required %h (n=%0d)", tag, got_i, exp_i, n);
    end
    tests++;
    if (got_d !== exp_d) begin
      fails++;
      $display("FAIL %s delayed: got flags/alg/rl/pcm=%b required %b (n=%0d)", tag, got_d, exp_d, n);
    end
  endtask

  task automatic tick(input bit do_check, input string tag);
    @(posedge clk);
    model_edge();
    #1;
    if (do_check) check_model(tag);
  endtask

  task automatic do_reset();
    rst = 1; clk_en = 1; cfg_we = 0; dac_en = 0;
    tick(1, "reset");
    rst = 0;
  endtask

  task automatic run_to(input int s);
    clk_en = 1;
    for (int i = 0; i < 48 && (n % 24) != s; i++) tick(1, "run");
    tests++;
    if ((n % 24) != s) begin
      fails++;
      $display("FAIL run_to: got position %0d required %0d", n % 24, s);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] f,
                            input logic [2:0] a, input logic [1:0] r);
    logic [8:0] got, exp;
    got = {s1_enters, s2_enters, s3_enters, s4_enters, alg, rl};
    exp = {f, a, r};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got flags/alg/rl=%b required %b", tag, got, exp);
    end
  endtask

  task automatic expect_int(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic       rst, en, we;
    logic [2:0] ch, a;
    logic [1:0] r;
    logic       dac;
    logic [4:0] e_slot;
    logic [3:0] e_flags;
    logic [2:0] e_alg;
    logic [1:0] e_rl;
    logic       e_pcm;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, pulses;
    logic [13:0] got_v, exp_v;

    //            rst en we ch   a    r     dac slot   flags    alg  rl    pcm
    vecs[0] = '{1'b1,1'b1,1'b0,3'd0,3'd0,2'd0,1'b0,5'd0,4'b0000,3'd0,2'd0,1'b0};
    vecs[1] = '{1'b0,1'b1,1'b0,3'd0,3'd0,2'd0,1'b0,5'd1,4'b0000,3'd0,2'd0,1'b0};
    vecs[2] = '{1'b0,1'b1,1'b0,3'd0,3'd0,2'd0,1'b0,5'd2,4'b0000,3'd0,2'd0,1'b0};
    vecs[3] = '{1'b0,1'b0,1'b0,3'd0,3'd0,2'd0,1'b0,5'd2,4'b0000,3'd0,2'd0,1'b0};
    vecs[4] = '{1'b0,1'b1,1'b0,3'd0,3'd0,2'd0,1'b0,5'd3,4'b0000,3'd0,2'd0,1'b0};
    vecs[5] = '{1'b0,1'b1,1'b0,3'd0,3'd0,2'd0,1'b0,5'd4,4'b1000,3'd0,2'd3,1'b0};
    vecs[6] = '{1'b0,1'b0,1'b1,3'd0,3'd6,2'd1,1'b0,5'd4,4'b1000,3'd0,2'd3,1'b0};
    vecs[7] = '{1'b0,1'b1,1'b0,3'd0,3'd0,2'd0,1'b0,5'd5,4'b1000,3'd0,2'd3,1'b0};
    vecs[8] = '{1'b0,1'b1,1'b0,3'd0,3'd0,2'd0,1'b0,5'd6,4'b1000,3'd0,2'd3,1'b0};

    rst = 1; clk_en = 1; cfg_we = 0; cfg_ch = 0; cfg_alg = 0; cfg_rl = 0; dac_en = 0;

    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].rst; clk_en = vecs[i].en; cfg_we = vecs[i].we;
      cfg_ch = vecs[i].ch; cfg_alg = vecs[i].a; cfg_rl = vecs[i].r; dac_en = vecs[i].dac;
      tick(0, "tbl");
      got_v = {slot, s1_enters, s2_enters, s3_enters, s4_enters, alg, rl, pcm_en};
      exp_v = {vecs[i].e_slot, vecs[i].e_flags, vecs[i].e_alg, vecs[i].e_rl, vecs[i].e_pcm};
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL tbl[%0d]: got slot/flags/alg/rl/pcm=%b required %b", i, got_v, exp_v);
      end
    end
    cfg_we = 0;

    // Warm-up timing and group sequence.
    do_reset();
    cnt = 0;
    for (int i = 0; i < 10 && !(s1_enters | s2_enters | s3_enters | s4_enters); i++) begin
      tick(1, "warm");
      cnt++;
    end
    expect_int("first_flag_cycle", cnt, OP_LAT);
    expect_out("first_s1", 4'b1000, 3'd0, 2'b11);
    for (int i = 0; i < 6; i++) tick(1, "seq");
    expect_out("s3_after_6", 4'b0010, 3'd0, 2'b11);
    for (int i = 0; i < 60; i++) tick(1, "cont");

    // Write to ch2 in the middle of its sum.
    do_reset();
    run_to(10);
    cfg_we = 1; cfg_ch = 2; cfg_alg = 7; cfg_rl = 2'b01;
    tick(1, "wr_ch2");
    cfg_we = 0;
    run_to(18);
    expect_out("ch2_old_frame", 4'b0100, 3'd0, 2'b11);
    run_to(6);
    expect_out("ch2_new_frame", 4'b1000, 3'd7, 2'b01);
    for (int i = 0; i < 24; i++) tick(1, "ch2_frame");

    // Same-cycle write on ch3's S1 slot.
    run_to(3);
    cfg_we = 1; cfg_ch = 3; cfg_alg = 5; cfg_rl = 2'b10;
    tick(1, "wr_ch3");
    cfg_we = 0;
    run_to(7);
    expect_out("ch3_bypass", 4'b1000, 3'd5, 2'b10);

    // dac_en raised mid-frame.
    do_reset();
    run_to(8);
    dac_en = 1;
    tick(1, "dac_set");
    pulses = 0;
    for (int i = 0; i < 30 && (n % 24) != 0; i++) begin
      tick(1, "dac_a");
      pulses += int'(pcm_en);
    end
    expect_int("pcm_same_frame", pulses, 0);
    pulses = 0;
    for (int i = 0; i < 28; i++) begin
      tick(1, "dac_b");
      pulses += int'(pcm_en);
    end
    expect_int("pcm_next_frame", pulses, 4);

    // clk_en 1-in-3.
    do_reset();
    for (int i = 0; i < 150; i++) begin
      clk_en = (i % 3 == 0);
      tick(1, "en3");
    end

    // Reset mid-frame with a dropped channel-6 write.
    do_reset();
    dac_en = 1;
    run_to(17);
    rst = 1; cfg_we = 1; cfg_ch = 6; cfg_alg = 7; cfg_rl = 2'b00;
    tick(1, "rst17");
    expect_out("rst17_flags", 4'b0000, 3'd0, 2'd0);
    rst = 0;
    tick(1, "ch6_wr");
    cfg_we = 0;
    for (int i = 0; i < 40; i++) tick(1, "after_rst");

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      clk_en  = ($urandom_range(0, 3) != 0);
      cfg_we  = ($urandom_range(0, 3) == 0);
      cfg_ch  = 3'($urandom_range(0, 7));
      cfg_alg = 3'($urandom_range(0, 7));
      cfg_rl  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) dac_en = ~dac_en;
      tick(1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
